// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyzer host interface.
//   cmd_state_t : command assembler states
//   rx_state_t  : UART receiver states
//   tx_state_t  : UART transmitter states
//   dbg_t       : bundle of all FSM states, exported for observation
//   FRAME_BITS  : start + 8 data + stop
//   ACK_CODE / NAK_CODE : response byte values used by the host protocol
//   cnt_w()     : counter width for a modulus, never below 1 bit
package la_pkg;

    typedef enum logic [1:0] {WAIT_HI, WAIT_LO, CMD_VALID} cmd_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    typedef struct packed {
        cmd_state_t cmd_st;
        rx_state_t  rx_st;
        tx_state_t  tx_st;
    } dbg_t;

    localparam int         FRAME_BITS = 10;
    localparam logic [7:0] ACK_CODE   = 8'hA5;
    localparam logic [7:0] NAK_CODE   = 8'hEE;

    function automatic int cnt_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_cmd_wrapper_xcvr.sv
// Byte-level UART transceiver, 8N1, full duplex with independent RX and TX.
//   clk, rst_n       : clock, async active-low reset
//   rx_i             : serial input (asynchronous, idle high)
//   rx_data_o        : received byte, valid while rx_rdy_o is high
//   rx_rdy_o         : one-cycle pulse, good stop bit seen
//   frame_err_o      : one-cycle pulse, stop bit read as 0 (byte dropped)
//   tx_o             : serial output (idle high)
//   tx_data_i        : byte to send, captured when tx_start_i is accepted
//   tx_start_i       : request a frame; ignored unless the transmitter is idle
//   tx_done_o        : one-cycle pulse on the last clock of the stop bit
//   rx_state_o, tx_state_o : FSM states for observation
module uart_xcvr
    import la_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_rdy_o,
    output logic       frame_err_o,
    output logic       tx_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_start_i,
    output logic       tx_done_o,
    output rx_state_t  rx_state_o,
    output tx_state_t  tx_state_o
);

    localparam int          BW        = cnt_w(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);

    // ---------------- RX ----------------
    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [BW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_s1_q    <= rx_i;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_rdy_o    = 1'b0;
        frame_err_o = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                // Half a bit in: still low means a real start bit, else a glitch.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BAUD_LAST) begin
                    rx_cnt_d    = '0;
                    rx_state_d  = RX_IDLE;
                    rx_rdy_o    = rx_s2_q;
                    frame_err_o = !rx_s2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign rx_data_o  = rx_shift_q;
    assign rx_state_o = rx_state_q;

    // ---------------- TX ----------------
    tx_state_t       tx_state_q, tx_state_d;
    logic [BW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [9:0]      tx_frame_q, tx_frame_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_frame_q <= '1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_frame_q <= tx_frame_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_frame_d = tx_frame_q;
        tx_done_o  = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (tx_start_i) begin
                    tx_state_d = TX_BUSY;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_frame_d = {1'b1, tx_data_i, 1'b0};
                end
            end
            TX_BUSY: begin
                // The shift register's bit 0 is always the level on the line.
                if (tx_cnt_q == BAUD_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 4'(FRAME_BITS - 1)) begin
                        tx_state_d = TX_IDLE;
                        tx_done_o  = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_frame_d = {1'b1, tx_frame_q[9:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign tx_o       = (tx_state_q == TX_BUSY) ? tx_frame_q[0] : 1'b1;
    assign tx_state_o = tx_state_q;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Host-side front end: pairs received bytes into 16-bit commands (high byte
// first) and sends 8-bit responses back over the UART.
//   clk, rst_n             : clock, async active-low reset
//   RX / TX                : serial lines to the host (idle high)
//   cmd, cmd_rdy           : assembled command and its valid flag
//   clr_cmd_rdy            : consumer retires cmd (one-cycle pulse)
//   resp, send_resp        : response byte and one-cycle send request
//   resp_sent              : one-cycle pulse on the last clock of the stop bit
//   frame_err              : one-cycle pulse on a bad received stop bit
//   dbg_o                  : all FSM states, for observation only
//
// Handshake: cmd_rdy rises with a new cmd and both hold steady until the
// consumer pulses clr_cmd_rdy; cmd_rdy drops on the following edge. Bytes
// that arrive while cmd_rdy is high are dropped. clr_cmd_rdy while cmd_rdy is
// low does nothing. send_resp is accepted only while the transmitter is idle.
module uart_cmd_wrapper
    import la_pkg::*;
#(
    parameter int BAUD_DIV    = 868,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        frame_err,
    output dbg_t        dbg_o
);

    localparam int          TW      = cnt_w(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [7:0] rx_data;
    logic       rx_rdy;
    rx_state_t  rx_state;
    tx_state_t  tx_state;

    uart_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (RX),
        .rx_data_o   (rx_data),
        .rx_rdy_o    (rx_rdy),
        .frame_err_o (frame_err),
        .tx_o        (TX),
        .tx_data_i   (resp),
        .tx_start_i  (send_resp),
        .tx_done_o   (resp_sent),
        .rx_state_o  (rx_state),
        .tx_state_o  (tx_state)
    );

    cmd_state_t      state_q, state_d;
    logic [7:0]      hi_q, hi_d;
    logic [15:0]     cmd_q, cmd_d;
    logic            rdy_q, rdy_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_HI;
            hi_q     <= '0;
            cmd_q    <= '0;
            rdy_q    <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            cmd_q    <= cmd_d;
            rdy_q    <= rdy_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        cmd_d    = cmd_q;
        rdy_d    = rdy_q;
        to_cnt_d = to_cnt_q;
        unique case (state_q)
            WAIT_HI: begin
                if (rx_rdy) begin
                    hi_d     = rx_data;
                    to_cnt_d = '0;
                    state_d  = WAIT_LO;
                end
            end
            WAIT_LO: begin
                // A byte landing on the expiry cycle still wins over the timeout.
                if (rx_rdy) begin
                    cmd_d   = {hi_q, rx_data};
                    rdy_d   = 1'b1;
                    state_d = CMD_VALID;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = WAIT_HI;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            CMD_VALID: begin
                if (clr_cmd_rdy) begin
                    rdy_d   = 1'b0;
                    state_d = WAIT_HI;
                end
            end
            default: state_d = WAIT_HI;
        endcase
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = rdy_q;
    assign dbg_o   = '{cmd_st: state_q, rx_st: rx_state, tx_st: tx_state};

endmodule
